// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for a bank of slide switches.
// Emits the debounced level together with registered rise/fall/any-change pulses.
module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q;
  logic [WIDTH-1:0]            s2_q;
  logic [WIDTH-1:0]            sw_q;
  logic [WIDTH-1:0]            sw_d;
  logic [WIDTH-1:0]            rise_q;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_q;
  logic [WIDTH-1:0]            fall_d;
  logic                        changed_q;
  logic                        changed_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

  // Each counter tracks how many consecutive edges s2 has disagreed with the
  // accepted level; any agreement, or an acceptance, restarts it from zero.
  always_comb begin
    cnt_d = cnt_q;
    sw_d  = sw_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST_CNT) begin
        sw_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Pulses are derived from the next level so they line up with the sw_out update.
  always_comb begin
    rise_d    = sw_d & ~sw_q;
    fall_d    = ~sw_d & sw_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sw_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= sw_in;
      s2_q      <= s1_q;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sw_out  = sw_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed and randomized checks of switch_debounce against a sliding-window reference model.
module tb_switch_debounce;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 5;

  // clock / reset
  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a bit flips once the last D pre-edge synchronised
  // samples all disagree with its current accepted level.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic         m_changed;
  logic [W-1:0] win[$];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] nxt;
    bit           all_diff;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
      win.delete();
    end else begin
      nxt = m_out;
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][i] == m_out[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_out[i];
        end
      end
      m_rise    = nxt & ~m_out;
      m_fall    = ~nxt & m_out;
      m_changed = |(nxt ^ m_out);
      m_out     = nxt;
      m_s2      = m_s1;
      m_s1      = sw_in;
    end
  end

  // scoreboard: every falling edge compares all outputs with the model
  always @(negedge clk) begin
    chk("sb_sw_out",  sw_out,           m_out);
    chk("sb_rise",    rise,             m_rise);
    chk("sb_fall",    fall,             m_fall);
    chk("sb_changed", W'(changed),      W'(m_changed));
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int hold;

    // reset with all switches high
    sw_in = 8'hFF;
    rst_n = 1'b0;
    cycles(3);
    chk("rst_sw_out", sw_out, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_changed", W'(changed), 8'h00);
    rst_n = 1'b1;
    cycles(5);
    chk("rel_edge5_sw_out", sw_out, 8'h00);
    cycles(1);
    chk("rel_edge6_sw_out", sw_out, 8'hFF);
    chk("rel_edge6_rise", rise, 8'hFF);
    chk("rel_edge6_changed", W'(changed), 8'h01);
    cycles(1);
    chk("rel_edge7_rise", rise, 8'h00);
    chk("rel_edge7_changed", W'(changed), 8'h00);

    // clean 00 -> 80
    sw_in = 8'h00;
    cycles(10);
    sw_in = 8'h80;
    cycles(5);
    chk("clean_edge5_sw_out", sw_out, 8'h00);
    cycles(1);
    chk("clean_edge6_sw_out", sw_out, 8'h80);
    chk("clean_edge6_rise", rise, 8'h80);
    chk("clean_edge6_fall", fall, 8'h00);
    chk("clean_edge6_changed", W'(changed), 8'h01);

    // bounce on bit 3: high 2, low 1, then steady high
    cycles(3);
    sw_in = 8'h88; cycles(2);
    sw_in = 8'h80; cycles(1);
    sw_in = 8'h88;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      if (rise[3]) pulses++;
    end
    chk("bounce_early_sw_out", sw_out, 8'h80);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (rise[3]) pulses++;
    end
    chk("bounce_rise3_pulses", W'(pulses), 8'h01);
    chk("bounce_final_sw_out", sw_out, 8'h88);

    // 3-cycle glitch on bit 0 from an all-low state
    sw_in = 8'h00;
    cycles(10);
    sw_in = 8'h01; cycles(3);
    sw_in = 8'h00;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      if (changed) pulses++;
    end
    chk("glitch_changed_pulses", W'(pulses), 8'h00);
    chk("glitch_sw_out", sw_out, 8'h00);

    // bits 7 and 0 swap on the same cycle
    sw_in = 8'h01;
    cycles(10);
    sw_in = 8'h80;
    cycles(5);
    chk("swap_edge5_sw_out", sw_out, 8'h01);
    cycles(1);
    chk("swap_edge6_sw_out", sw_out, 8'h80);
    chk("swap_edge6_rise", rise, 8'h80);
    chk("swap_edge6_fall", fall, 8'h01);
    chk("swap_edge6_changed", W'(changed), 8'h01);
    cycles(1);
    chk("swap_edge7_changed", W'(changed), 8'h00);

    // reset dropped mid-count
    sw_in = 8'h81;
    cycles(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sw_out", sw_out, 8'h00);
    chk("midrst_rise", rise, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(5);
    chk("midrst_edge5_sw_out", sw_out, 8'h00);
    cycles(1);
    chk("midrst_edge6_sw_out", sw_out, 8'h81);
    chk("midrst_edge6_rise", rise, 8'h81);

    // randomized stimulus with occasional asynchronous resets
    for (int n = 0; n < 300; n++) begin
      sw_in = W'($urandom);
      if ($urandom_range(0, 3) == 0) sw_in = sw_out ^ W'(1 << $urandom_range(0, W - 1));
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 39) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycles(hold);
    end
    cycles(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
